// File: rtl/boot_rom_pkg.sv
// Shared types for the boot ROM arbiter slice.
package boot_rom_pkg;

  localparam int ROM_AW = 10;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e owner;
    logic  err;
  } rsp_pend_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
  endfunction

endpackage

// File: rtl/boot_rom_arb_pick.sv
// Two-way request picker; BOOT_ROM_ARB_RR_EN selects round-robin,
// otherwise instr has fixed priority over data.
module boot_rom_arb_pick
  import boot_rom_pkg::*;
(
  input  logic  req_instr_i,
  input  logic  req_data_i,
  input  port_e ptr_i,
  output logic  gnt_instr_o,
  output logic  gnt_data_o
);

`ifdef BOOT_ROM_ARB_RR_EN
  always_comb begin
    gnt_instr_o = 1'b0;
    gnt_data_o  = 1'b0;
    unique case (1'b1)
      (req_instr_i && !req_data_i): gnt_instr_o = 1'b1;
      (!req_instr_i && req_data_i): gnt_data_o  = 1'b1;
      (req_instr_i && req_data_i): begin
        gnt_instr_o = (ptr_i == PORT_INSTR);
        gnt_data_o  = (ptr_i == PORT_DATA);
      end
      default: ;
    endcase
  end
`else
  logic unused_ptr;
  assign unused_ptr  = ptr_i;
  assign gnt_instr_o = req_instr_i;
  assign gnt_data_o  = req_data_i & ~req_instr_i;
`endif

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares one synchronous boot ROM between instr and data ports.
// Policy: BOOT_ROM_ARB_RR_EN (round-robin) or fixed instr priority.
module boot_rom_arbiter
  import boot_rom_pkg::*;
#(
  parameter int ROM_WORDS = 548,
  parameter int ADDR_W    = 12
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i
);

  localparam logic [ROM_AW:0] LIM = (ROM_AW+1)'(ROM_WORDS);

  logic              pick_i, pick_d;
  logic              acc_i, acc_d, acc;
  logic [ADDR_W-1:0] addr;
  logic              we, legal, rom_en;
  logic [ROM_AW-1:0] idx, rom_a_d, rom_a_q;
  rsp_pend_t         pend_d, pend_q;
  port_e             ptr;
  logic              rv_i, rv_d;

  boot_rom_arb_pick u_pick (
    .req_instr_i (instr_req_i),
    .req_data_i  (data_req_i),
    .ptr_i       (ptr),
    .gnt_instr_o (pick_i),
    .gnt_data_o  (pick_d)
  );

  // No grants while held in reset so the ROM stays deselected.
  assign instr_gnt_o = pick_i & RSTN;
  assign data_gnt_o  = pick_d & RSTN;

  always_comb begin
    acc_i   = instr_req_i & instr_gnt_o;
    acc_d   = data_req_i & data_gnt_o;
    acc     = acc_i | acc_d;
    addr    = acc_d ? data_addr_i : instr_addr_i;
    we      = acc_d & data_we_i;
    idx     = addr[ROM_AW+1:2];
    legal   = !we && (addr[1:0] == 2'b00) && ({1'b0, idx} < LIM);
    rom_en  = acc & legal;
    rom_a_d = rom_en ? idx : rom_a_q;
    pend_d       = '0;
    pend_d.valid = acc;
    pend_d.owner = acc_d ? PORT_DATA : PORT_INSTR;
    pend_d.err   = acc & ~legal;
  end

  assign rom_csn_o = ~rom_en;
  assign rom_a_o   = rom_a_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rom_a_q <= '0;
      pend_q  <= '0;
    end else begin
      rom_a_q <= rom_a_d;
      pend_q  <= pend_d;
    end
  end

`ifdef BOOT_ROM_ARB_RR_EN
  port_e ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (instr_req_i && data_req_i && acc)
      ptr_d = other_port(acc_d ? PORT_DATA : PORT_INSTR);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) ptr_q <= PORT_INSTR;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = PORT_INSTR;
`endif

  always_comb begin
    rv_i = pend_q.valid && (pend_q.owner == PORT_INSTR);
    rv_d = pend_q.valid && (pend_q.owner == PORT_DATA);
    instr_rvalid_o = rv_i;
    data_rvalid_o  = rv_d;
    instr_err_o    = rv_i & pend_q.err;
    data_err_o     = rv_d & pend_q.err;
    instr_rdata_o  = (rv_i && !pend_q.err) ? rom_q_i : '0;
    data_rdata_o   = (rv_d && !pend_q.err) ? rom_q_i : '0;
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench for boot_rom_arbiter with a behavioural ROM.
module tb_boot_rom_arbiter;
  import boot_rom_pkg::*;

`ifdef BOOT_ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        instr_req_i, data_req_i, data_we_i;
  logic [11:0] instr_addr_i, data_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, rom_q_i;
  logic        rom_csn_o;
  logic [9:0]  rom_a_o;

  always #5 CLK = ~CLK;

  boot_rom_arbiter #(.ROM_WORDS(548), .ADDR_W(12)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o),
    .rom_csn_o(rom_csn_o), .rom_a_o(rom_a_o), .rom_q_i(rom_q_i)
  );

  function automatic logic [31:0] romw(input int i);
    if (i == 31) return 32'h0100_006F;
    return 32'h9E37_0000 ^ (i * 32'h0001_0203);
  endfunction

  always_ff @(posedge CLK)
    if (!rom_csn_o) rom_q_i <= romw(int'(rom_a_o));

  typedef struct {
    logic        ir;
    logic [11:0] ia;
    logic        dr;
    logic [11:0] da;
    logic        dwe;
    logic        eig;
    logic        edg;
    string       tag;
  } vec_t;

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  int         nchk = 0;
  int         nerr = 0;
  logic [9:0] exp_a;
  vec_t       tbl[16];

  function void chk(input string nm, input logic [31:0] act,
                    input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  task automatic check_rsp(input string tag);
    exp_t e;
    logic vi, vd;
    vi = 1'b0; vd = 1'b0;
    e  = '{owner: 1'b0, err: 1'b0, data: 32'h0};
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      vi = !e.owner;
      vd = e.owner;
    end
    chk({tag, " i_rvalid"}, 32'(instr_rvalid_o), 32'(vi));
    chk({tag, " d_rvalid"}, 32'(data_rvalid_o), 32'(vd));
    chk({tag, " i_err"}, 32'(instr_err_o), 32'(vi & e.err));
    chk({tag, " d_err"}, 32'(data_err_o), 32'(vd & e.err));
    chk({tag, " i_rdata"}, instr_rdata_o, vi ? e.data : 32'h0);
    chk({tag, " d_rdata"}, data_rdata_o, vd ? e.data : 32'h0);
  endtask

  task automatic step(input vec_t v);
    logic        acc, own, we, legal;
    logic [11:0] a;
    logic [9:0]  idx;
    instr_req_i  = v.ir;
    instr_addr_i = v.ia;
    data_req_i   = v.dr;
    data_addr_i  = v.da;
    data_we_i    = v.dwe;
    #1;
    check_rsp(v.tag);
    chk({v.tag, " i_gnt"}, 32'(instr_gnt_o), 32'(v.eig));
    chk({v.tag, " d_gnt"}, 32'(data_gnt_o), 32'(v.edg));
    acc = (v.ir & v.eig) | (v.dr & v.edg);
    own = v.dr & v.edg;
    a   = own ? v.da : v.ia;
    we  = own & v.dwe;
    idx = a[11:2];
    legal = !we && (a[1:0] == 2'b00) && (int'(idx) < 548);
    if (acc && legal) begin
      chk({v.tag, " csn"}, 32'(rom_csn_o), 32'h0);
      chk({v.tag, " rom_a"}, 32'(rom_a_o), 32'(idx));
      exp_a = idx;
    end else begin
      chk({v.tag, " csn"}, 32'(rom_csn_o), 32'h1);
      chk({v.tag, " rom_a"}, 32'(rom_a_o), 32'(exp_a));
    end
    if (acc)
      sb.push_back('{owner: own, err: !legal,
                     data: legal ? romw(int'(idx)) : 32'h0});
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " csn"}, 32'(rom_csn_o), 32'h1);
    chk({tag, " rom_a"}, 32'(rom_a_o), 32'h0);
    chk({tag, " i_rvalid"}, 32'(instr_rvalid_o), 32'h0);
    chk({tag, " d_rvalid"}, 32'(data_rvalid_o), 32'h0);
    chk({tag, " errs"}, 32'({instr_err_o, data_err_o}), 32'h0);
    chk({tag, " rdata"}, instr_rdata_o | data_rdata_o, 32'h0);
  endtask

  vec_t idle;

  initial begin
    idle = '{0, 12'h0, 0, 12'h0, 0, 0, 0, "idle"};
    tbl[0]  = '{1, 12'h07C, 0, 12'h0, 0, 1, 0, "instr_w31"};
    tbl[1]  = idle;
    tbl[2]  = '{0, 12'h0, 1, 12'h010, 0, 0, 1, "data_rd"};
    tbl[3]  = '{0, 12'h0, 1, 12'h000, 1, 0, 1, "data_wr"};
    tbl[4]  = '{0, 12'h0, 1, 12'h890, 0, 0, 1, "oor_548"};
    tbl[5]  = '{0, 12'h0, 1, 12'h002, 0, 0, 1, "misalign"};
    tbl[6]  = '{1, 12'h000, 0, 12'h0, 0, 1, 0, "b2b_0"};
    tbl[7]  = '{1, 12'h004, 0, 12'h0, 0, 1, 0, "b2b_4"};
    tbl[8]  = '{1, 12'h88C, 0, 12'h0, 0, 1, 0, "last_547"};
    tbl[9]  = '{1, 12'h001, 0, 12'h0, 0, 1, 0, "i_misal"};
    tbl[10] = '{1, 12'h100, 1, 12'h200, 0, 1, 0, "cont0"};
    tbl[11] = '{1, 12'h104, 1, 12'h204, 0, !RR, RR, "cont1"};
    tbl[12] = '{1, 12'h108, 1, 12'h208, 0, 1, 0, "cont2"};
    tbl[13] = '{1, 12'h10C, 1, 12'h20C, 0, !RR, RR, "cont3"};
    tbl[14] = idle;
    tbl[15] = '{1, 12'hFFC, 0, 12'h0, 0, 1, 0, "oor_top"};

    RSTN = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 12'h07C;
    data_req_i = 1'b1; data_addr_i = 12'h004; data_we_i = 1'b0;
    exp_a = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("por");
    RSTN = 1'b1;
    instr_req_i = 1'b0; data_req_i = 1'b0;

    foreach (tbl[i]) step(tbl[i]);
    step(idle);

    // Leave the RR pointer on data, then reset with a response pending.
    step('{1, 12'h040, 1, 12'h044, 0, 1, 0, "pre_cont"});
    step('{1, 12'h07C, 0, 12'h0, 0, 1, 0, "pre_rst"});
    RSTN = 1'b0;
    instr_req_i = 1'b0; data_req_i = 1'b0;
    sb.delete();
    exp_a = '0;
    #1;
    check_reset_state("rst_mid");
    @(posedge CLK);
    #1;
    check_reset_state("rst_hold");
    RSTN = 1'b1;
    step('{1, 12'h07C, 1, 12'h008, 0, 1, 0, "post_rst"});
    step(idle);
    step(idle);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
